// File: rtl/sram_mem_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: FSM encodings and port selects.
package sram_mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/sram_mem_arbiter_if.sv
// Arbiter <-> SRAM controller bus. master = arbiter, slave = controller.
interface sram_mem_arbiter_if;
  logic        enable;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rd_done;
  logic        wr_done;

  modport master (output enable, we, addr, wdata, input rdata, rd_done, wr_done);
  modport slave  (input enable, we, addr, wdata, output rdata, rd_done, wr_done);
endinterface

// File: rtl/sram_mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of the SRAM controller.
// Data wins ties; one transfer in flight; misaligned and hung accesses
// come back as ready+err with zeroed read data.
module sram_mem_arbiter
  import sram_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT   = 512,
  parameter int ADDR_BITS = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        stall,
  output logic        err,
  sram_mem_arbiter_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]           state;
  logic                 port_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] waddr_q;
  logic [31:0]          wdata_q;
  logic [CW-1:0]        cnt;

  logic [31:0] sel_addr;
  logic        accept;
  logic        misal;
  logic        done_in;
  logic        tmo;
  logic        unused_addr_bits;

  assign sel_addr = d_req ? d_addr : i_addr;
  // A ready pulse in flight means the requester has not yet dropped req;
  // hold off so the same request is not granted twice.
  assign accept   = (state == ST_IDLE) & (i_req | d_req) & ~(i_ready | d_ready);
  assign misal    = |sel_addr[1:0];
  assign done_in  = we_q ? mem.wr_done : mem.rd_done;
  assign tmo      = (cnt == CW'(TIMEOUT - 1));
  assign unused_addr_bits = ^sel_addr[31:ADDR_BITS+2];

  assign stall      = (i_req | d_req) & ~(i_ready | d_ready);
  assign mem.enable = (state == ST_ISSUE) | (state == ST_WAIT);
  assign mem.we     = mem.enable & we_q;
  assign mem.addr   = 32'({waddr_q, 1'b0});
  assign mem.wdata  = wdata_q;

  // Arbitration FSM, request latches, timeout counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      port_q  <= PORT_I;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (misal) begin
              err <= 1'b1;
              if (d_req) begin d_ready <= 1'b1; d_rdata <= '0; end
              else       begin i_ready <= 1'b1; i_rdata <= '0; end
            end else begin
              port_q  <= d_req ? PORT_D : PORT_I;
              we_q    <= d_req & d_we;
              waddr_q <= sel_addr[ADDR_BITS+1:2];
              wdata_q <= d_wdata;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_in) begin
            if (port_q == PORT_D) begin
              d_ready <= 1'b1;
              if (!we_q) d_rdata <= mem.rdata;
            end else begin
              i_ready <= 1'b1;
              i_rdata <= mem.rdata;
            end
            state <= ST_DRAIN;
          end else if (tmo) begin
            err <= 1'b1;
            if (port_q == PORT_D) begin d_ready <= 1'b1; d_rdata <= '0; end
            else                  begin i_ready <= 1'b1; i_rdata <= '0; end
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // One long done level must not retrigger the next transfer.
          if (!mem.rd_done && !mem.wr_done) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
